vga_line_fetch: RTL

Ping-pong line prefetcher between the data-memory framebuffer port and the VGA pixel output path. On a line-start request it reads one line of 1-bpp pixel words from memory into the back buffer. On an end-of-line swap it makes that buffer active. It then shifts pixels out one per pixel-enable. It runs entirely in the `pixel_clk` domain, with the memory read port on the address side and the scan-out timing logic on the pixel side.

---
 rtl/vga_line_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vga_line_fetch.sv
// Ping-pong line prefetcher: fills the back buffer from the framebuffer port
// and scans the active buffer out one 1-bpp pixel per pixel enable.
module vga_line_fetch #(
  parameter int WPL = 4,
  parameter int AW  = 9
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [6:0]    line_idx,
  output logic [AW-1:0] raddr,
  input  logic [31:0]   rdata,
  input  logic          swap,
  input  logic          pix_en,
  output logic          pix_out,
  output logic          busy,
  output logic          underrun
);

  localparam int NPIX = WPL * 32;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int WW   = (WPL > 1) ? $clog2(WPL) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_reg;
  logic            act_reg;
  logic            tgt_reg;
  logic            back_valid_reg;
  logic            underrun_reg;
  logic [AW-1:0]   base_reg;
  logic [AW-1:0]   raddr_reg;
  logic [WW-1:0]   k_reg;
  logic [PW-1:0]   pcnt_reg;
  logic [31:0]     line_buf [2][WPL];

  logic            act_next;
  logic [AW-1:0]   base_next;
  logic            wr_en;
  logic [WW-1:0]   wr_word;
  logic [WW-1:0]   pix_word;
  logic [4:0]      pix_bit;

  // A same-cycle swap is resolved first so a new fetch targets the buffer
  // that has just stopped being displayed.
  assign act_next  = (swap && back_valid_reg) ? ~act_reg : act_reg;
  assign base_next = AW'(line_idx) * AW'(WPL);

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      act_reg        <= 1'b0;
      tgt_reg        <= 1'b0;
      back_valid_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      base_reg       <= '0;
      raddr_reg      <= '0;
      k_reg          <= '0;
      pcnt_reg       <= PW'(NPIX);
    end else begin
      act_reg <= act_next;
      if (swap) begin
        if (back_valid_reg) back_valid_reg <= 1'b0;
        else                underrun_reg   <= 1'b1;
        pcnt_reg <= '0;
      end else if (pix_en && (pcnt_reg != PW'(NPIX))) begin
        pcnt_reg <= pcnt_reg + PW'(1);
      end

      unique case (state_reg)
        IDLE: begin
          if (line_start) begin
            base_reg       <= base_next;
            raddr_reg      <= base_next;
            tgt_reg        <= ~act_next;
            back_valid_reg <= 1'b0;
            k_reg          <= '0;
            state_reg      <= FETCH;
          end
        end
        FETCH: begin
          k_reg <= k_reg + WW'(1);
          if (k_reg == WW'(WPL - 1)) state_reg <= DRAIN;
          else raddr_reg <= base_reg + AW'(k_reg) + AW'(1);
        end
        DRAIN: begin
          back_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read data lags the address by one cycle, so each write lands one word behind k.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    if (state_reg == FETCH && k_reg != '0) begin
      wr_en   = 1'b1;
      wr_word = k_reg - WW'(1);
    end else if (state_reg == DRAIN) begin
      wr_en   = 1'b1;
      wr_word = WW'(WPL - 1);
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < WPL; w++)
          line_buf[b][w] <= '0;
    end else if (wr_en) begin
      line_buf[tgt_reg][wr_word] <= rdata;
    end
  end

  assign pix_word = pcnt_reg[5 +: WW];
  assign pix_bit  = 5'd31 - pcnt_reg[4:0];

  always_comb begin
    pix_out = 1'b0;
    if (pcnt_reg < PW'(NPIX)) pix_out = line_buf[act_reg][pix_word][pix_bit];
  end

  assign raddr    = raddr_reg;
  assign busy     = (state_reg != IDLE);
  assign underrun = underrun_reg;

endmodule
